// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I ALU/branch/jump execution unit feeding an in-order result queue toward the CDB.
module alu_exec_unit #(
   parameter int XLEN    = 32,
   parameter int ENTRY_W = 4,
   parameter int QDEPTH  = 4
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      rdy_in,
   input  logic                      flush_in,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [5:0]                in_op,
   input  logic [XLEN-1:0]           in_vj,
   input  logic [XLEN-1:0]           in_vk,
   input  logic [XLEN-1:0]           in_imm,
   input  logic [XLEN-1:0]           in_pc,
   input  logic [ENTRY_W-1:0]        in_des,
   output logic                      out_valid,
   input  logic                      out_grant,
   output logic [XLEN-1:0]           out_result,
   output logic [XLEN-1:0]           out_pc,
   output logic                      out_jump,
   output logic [ENTRY_W-1:0]        out_des,
   output logic [$clog2(QDEPTH):0]   occupancy
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(XLEN);
   localparam logic [5:0] ADD = 6'd1, SUB = 6'd2, SLL = 6'd3, SLT = 6'd4, SLTU = 6'd5,
      XOR = 6'd6, SRL = 6'd7, SRA = 6'd8, OR = 6'd9, AND = 6'd10, ADDI = 6'd11, SLTI = 6'd12,
      SLTIU = 6'd13, XORI = 6'd14, ORI = 6'd15, ANDI = 6'd16, SLLI = 6'd17, SRLI = 6'd18,
      SRAI = 6'd19, BEQ = 6'd20, BNE = 6'd21, BLT = 6'd22, BGE = 6'd23, BLTU = 6'd24,
      BGEU = 6'd25, JAL = 6'd26, JALR = 6'd27, LUI = 6'd28, AUIPC = 6'd29;

   typedef struct packed {
      logic [XLEN-1:0]    res;
      logic [XLEN-1:0]    npc;
      logic               jmp;
      logic [ENTRY_W-1:0] des;
   } entry_t;

   entry_t          mem [QDEPTH];
   entry_t          head, new_e;
   logic [PW-1:0]   rd_ptr, wr_ptr, rd_nx;
   logic [CW-1:0]   count, cnt_nx;
   logic            accept, pop, flush, taken, is_br;
   logic [XLEN-1:0] res, npc, pc4, target;
   logic [SW-1:0]   sh_r, sh_i;

   assign pc4    = in_pc + XLEN'(4);
   assign target = in_pc + in_imm;
   assign sh_r   = in_vk[SW-1:0];
   assign sh_i   = in_imm[SW-1:0];

   always_comb begin
      res   = '0;
      npc   = pc4;
      taken = 1'b0;
      is_br = 1'b0;
      new_e.jmp = 1'b0;
      case (in_op)
         ADD:   res = in_vj + in_vk;
         SUB:   res = in_vj - in_vk;
         SLL:   res = in_vj << sh_r;
         SLT:   res = XLEN'($signed(in_vj) < $signed(in_vk));
         SLTU:  res = XLEN'(in_vj < in_vk);
         XOR:   res = in_vj ^ in_vk;
         SRL:   res = in_vj >> sh_r;
         SRA:   res = $unsigned($signed(in_vj) >>> sh_r);
         OR:    res = in_vj | in_vk;
         AND:   res = in_vj & in_vk;
         ADDI:  res = in_vj + in_imm;
         SLTI:  res = XLEN'($signed(in_vj) < $signed(in_imm));
         SLTIU: res = XLEN'(in_vj < in_imm);
         XORI:  res = in_vj ^ in_imm;
         ORI:   res = in_vj | in_imm;
         ANDI:  res = in_vj & in_imm;
         SLLI:  res = in_vj << sh_i;
         SRLI:  res = in_vj >> sh_i;
         SRAI:  res = $unsigned($signed(in_vj) >>> sh_i);
         BEQ:   begin is_br = 1'b1; taken = in_vj == in_vk; end
         BNE:   begin is_br = 1'b1; taken = in_vj != in_vk; end
         BLT:   begin is_br = 1'b1; taken = $signed(in_vj) < $signed(in_vk); end
         BGE:   begin is_br = 1'b1; taken = $signed(in_vj) >= $signed(in_vk); end
         BLTU:  begin is_br = 1'b1; taken = in_vj < in_vk; end
         BGEU:  begin is_br = 1'b1; taken = in_vj >= in_vk; end
         JAL:   begin res = pc4; npc = target; new_e.jmp = 1'b1; end
         JALR:  begin res = pc4; npc = (in_vj + in_imm) & ~XLEN'(1); new_e.jmp = 1'b1; end
         LUI:   res = in_imm;
         AUIPC: res = target;
         default: ;
      endcase
      if (is_br) begin
         res       = XLEN'(taken);
         npc       = taken ? target : pc4;
         new_e.jmp = taken;
      end
      new_e.res = res;
      new_e.npc = npc;
      new_e.des = in_des;
   end

   assign in_ready  = (count < CW'(QDEPTH)) && !flush_in;
   assign out_valid = count != '0;
   assign occupancy = count;
   assign flush     = flush_in && rdy_in;
   assign accept    = in_valid && in_ready && rdy_in;
   assign pop       = out_valid && out_grant && rdy_in && !flush_in;
   assign rd_nx     = pop ? rd_ptr + PW'(1) : rd_ptr;
   assign cnt_nx    = flush ? '0 : count + CW'(accept) - CW'(pop);
   assign {out_result, out_pc, out_jump, out_des} = head;

   // Head is re-registered so that an emptied queue keeps presenting the last head.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         head   <= '0;
         for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
      end else if (rdy_in) begin
         rd_ptr <= flush ? '0 : rd_nx;
         wr_ptr <= flush ? '0 : accept ? wr_ptr + PW'(1) : wr_ptr;
         count  <= cnt_nx;
         if (accept) mem[wr_ptr] <= new_e;
         if (cnt_nx != '0) head <= (accept && wr_ptr == rd_nx) ? new_e : mem[rd_nx];
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vector table plus hand-written queue/reset/flush sequences.
module tb_alu_exec_unit;
   localparam logic [5:0] ADD = 6'd1, SUB = 6'd2, SLL = 6'd3, SLT = 6'd4, SLTU = 6'd5,
      XOR = 6'd6, SRA = 6'd8, ADDI = 6'd11, SRLI = 6'd18, SRAI = 6'd19, BEQ = 6'd20,
      BLT = 6'd22, BGE = 6'd23, BLTU = 6'd24, JAL = 6'd26, JALR = 6'd27, LUI = 6'd28,
      AUIPC = 6'd29, UNDEF = 6'd63;

   logic        clk = 0, rst_n_in, rdy_in, flush_in, in_valid, in_ready, out_valid, out_grant, out_jump;
   logic [5:0]  in_op;
   logic [31:0] in_vj, in_vk, in_imm, in_pc, out_result, out_pc;
   logic [3:0]  in_des, out_des;
   logic [2:0]  occupancy;
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   alu_exec_unit dut (
      .clk_in(clk), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_vj(in_vj), .in_vk(in_vk),
      .in_imm(in_imm), .in_pc(in_pc), .in_des(in_des), .out_valid(out_valid),
      .out_grant(out_grant), .out_result(out_result), .out_pc(out_pc), .out_jump(out_jump),
      .out_des(out_des), .occupancy(occupancy)
   );

   typedef struct {
      logic [5:0]  op;
      logic [31:0] vj, vk, imm, pc, r, npc;
      logic        j;
   } vec_t;

   vec_t v [19];

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic put(input logic [5:0] op, input logic [31:0] vj, vk, imm, pc,
                      input logic [3:0] des, input logic vld);
      in_op = op; in_vj = vj; in_vk = vk; in_imm = imm; in_pc = pc; in_des = des; in_valid = vld;
   endtask

   initial begin
      v[0]  = '{ADD,   32'd5,        32'd7,        32'd0,        32'h10,   32'd12,       32'h14,  1'b0};
      v[1]  = '{SUB,   32'd3,        32'd5,        32'd0,        32'h20,   32'hFFFFFFFE, 32'h24,  1'b0};
      v[2]  = '{ADDI,  32'hFFFFFFFF, 32'd0,        32'd1,        32'h30,   32'd0,        32'h34,  1'b0};
      v[3]  = '{SRAI,  32'h80000000, 32'd0,        32'd4,        32'h40,   32'hF8000000, 32'h44,  1'b0};
      v[4]  = '{SRLI,  32'h80000000, 32'd0,        32'd4,        32'h40,   32'h08000000, 32'h44,  1'b0};
      v[5]  = '{SLTU,  32'd1,        32'hFFFFFFFF, 32'd0,        32'h50,   32'd1,        32'h54,  1'b0};
      v[6]  = '{SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        32'h50,   32'd0,        32'h54,  1'b0};
      v[7]  = '{SLL,   32'd1,        32'h25,       32'd0,        32'h60,   32'h20,       32'h64,  1'b0};
      v[8]  = '{XOR,   32'hF0F0,     32'h0FF0,     32'd0,        32'h60,   32'hFF00,     32'h64,  1'b0};
      v[9]  = '{LUI,   32'd0,        32'd0,        32'h12345000, 32'h70,   32'h12345000, 32'h74,  1'b0};
      v[10] = '{AUIPC, 32'd0,        32'd0,        32'h2000,     32'h1000, 32'h3000,     32'h1004, 1'b0};
      v[11] = '{BLT,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd1,        32'h120, 1'b1};
      v[12] = '{BGE,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        32'h104, 1'b0};
      v[13] = '{JALR,  32'h203,      32'd0,        32'd0,        32'h300,  32'h304,      32'h202, 1'b1};
      v[14] = '{JAL,   32'd0,        32'd0,        32'hFFFFFFF0, 32'h400,  32'h404,      32'h3F0, 1'b1};
      v[15] = '{BEQ,   32'd7,        32'd7,        32'd8,        32'h50,   32'd1,        32'h58,  1'b1};
      v[16] = '{UNDEF, 32'd9,        32'd9,        32'd9,        32'h500,  32'd0,        32'h504, 1'b0};
      v[17] = '{SRA,   32'hF0000000, 32'h24,       32'd0,        32'h600,  32'hFF000000, 32'h604, 1'b0};
      v[18] = '{BLTU,  32'd1,        32'hFFFFFFFF, 32'h10,       32'h80,   32'd1,        32'h90,  1'b1};

      rst_n_in = 0; rdy_in = 1; flush_in = 0; out_grant = 0;
      put(6'd0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("reset_state", {out_valid, occupancy, in_ready, out_result, out_pc, out_jump, out_des},
          {1'b0, 3'd0, 1'b1, 32'd0, 32'd0, 1'b0, 4'd0});
      rst_n_in = 1;

      // reset mid-stream
      for (int i = 1; i <= 3; i++) begin
         put(ADD, i, 0, 0, 0, 4'(i), 1);
         @(negedge clk);
      end
      in_valid = 0;
      chk("pre_reset_occ", occupancy, 3'd3);
      #2 rst_n_in = 0;
      #1 chk("async_reset", {out_valid, occupancy}, {1'b0, 3'd0});
      @(negedge clk);
      rst_n_in = 1;
      put(ADD, 32'd2, 32'd3, 0, 32'h8, 4'd9, 1);
      @(negedge clk);
      in_valid = 0;
      chk("post_reset_head", {out_valid, out_result, out_des}, {1'b1, 32'd5, 4'd9});
      out_grant = 1;
      @(negedge clk);
      out_grant = 0;

      // vector table, one op at a time
      for (int i = 0; i < 19; i++) begin
         put(v[i].op, v[i].vj, v[i].vk, v[i].imm, v[i].pc, 4'(i), 1);
         @(negedge clk);
         in_valid = 0;
         chk($sformatf("vec%0d", i), {out_valid, out_result, out_pc, out_jump, out_des},
             {1'b1, v[i].r, v[i].npc, v[i].j, 4'(i)});
         out_grant = 1;
         @(negedge clk);
         out_grant = 0;
         chk($sformatf("vec%0d_pop", i), {out_valid, occupancy}, {1'b0, 3'd0});
      end

      // fill and backpressure
      for (int i = 0; i < 4; i++) begin
         put(ADD, 0, 0, 0, 0, 4'(4 + i), 1);
         @(negedge clk);
      end
      chk("full", {occupancy, in_ready}, {3'd4, 1'b0});
      put(ADD, 0, 0, 0, 0, 4'd8, 1);
      @(negedge clk);
      in_valid = 0;
      chk("full_hold", {occupancy, out_des}, {3'd4, 4'd4});
      out_grant = 1;
      @(negedge clk);
      out_grant = 0;
      chk("after_grant", {in_ready, occupancy}, {1'b1, 3'd3});
      for (int i = 5; i < 8; i++) begin
         chk($sformatf("fill_order%0d", i), {out_valid, out_des}, {1'b1, 4'(i)});
         out_grant = 1;
         @(negedge clk);
      end
      out_grant = 0;
      chk("drained", {out_valid, occupancy, out_des}, {1'b0, 3'd0, 4'd7});

      // simultaneous accept + pop across pointer wrap
      for (int i = 0; i < 2; i++) begin
         put(ADD, 0, 0, 0, 0, 4'(i), 1);
         @(negedge clk);
      end
      out_grant = 1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("stream%0d", i), {occupancy, out_des}, {3'd2, 4'(i)});
         put(ADD, 0, 0, 0, 0, 4'(i + 2), 1);
         @(negedge clk);
      end
      in_valid = 0; out_grant = 0;
      chk("stream_end", {occupancy, out_des}, {3'd2, 4'd10});

      // flush with rdy_in high, incoming op dropped
      flush_in = 1;
      put(ADD, 0, 0, 0, 0, 4'd3, 1);
      #1 chk("flush_ready", in_ready, 1'b0);
      @(negedge clk);
      flush_in = 0; in_valid = 0;
      chk("flush", {out_valid, occupancy}, {1'b0, 3'd0});
      for (int i = 0; i < 3; i++) begin
         put(ADD, 0, 0, 0, 0, 4'(11 + i), 1);
         @(negedge clk);
      end
      chk("refill", occupancy, 3'd3);
      rdy_in = 0; flush_in = 1; out_grant = 1;
      put(ADD, 0, 0, 0, 0, 4'd15, 1);
      @(negedge clk);
      chk("frozen_flush", {out_valid, occupancy, out_des}, {1'b1, 3'd3, 4'd11});
      rdy_in = 1;
      @(negedge clk);
      flush_in = 0; in_valid = 0; out_grant = 0;
      chk("final_flush", {out_valid, occupancy}, {1'b0, 3'd0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
